// File: rtl/dm_arbiter.sv
// Two-port (CPU/DMA) round-robin arbiter in front of a single-port data memory.
// Each granted access runs IDLE -> ACCESS -> RESP, one transaction per 3 cycles.
module dm_arbiter #(
   parameter int MEM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        c_req,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_wdata,
   input  logic [3:0]  c_byteen,
   output logic [31:0] c_rdata,
   output logic        c_ack,
   output logic        c_err,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_byteen,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        d_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_byteen,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;

   logic        pick_dma;
   logic        win_q;
   logic        last_q;
   logic        inr_q;
   logic        inr_d;
   logic        start;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [3:0]  sel_be;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic [31:0] rd_val;
   logic [31:0] c_rdata_q;
   logic [31:0] d_rdata_q;

   // win_q/last_q encoding: 0 = CPU, 1 = DMA
   always_comb begin
      pick_dma = 1'b0;
      priority case (1'b1)
         c_req && d_req: pick_dma = ~last_q;
         d_req:          pick_dma = 1'b1;
         default:        pick_dma = 1'b0;
      endcase
   end

   assign start     = (state_q == IDLE) && (c_req || d_req);
   assign sel_addr  = pick_dma ? d_addr : c_addr;
   assign sel_wdata = pick_dma ? d_wdata : c_wdata;
   assign sel_be    = pick_dma ? d_byteen : c_byteen;
   assign inr_d     = (sel_addr >> 2) < 32'(MEM_WORDS);
   assign rd_val    = inr_q ? mem_rdata : 32'h0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = (c_req || d_req) ? ACCESS : IDLE;
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         win_q     <= 1'b0;
         last_q    <= 1'b1;
         inr_q     <= 1'b0;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         be_q      <= 4'h0;
         c_rdata_q <= 32'h0;
         d_rdata_q <= 32'h0;
      end else begin
         if (start) begin
            win_q   <= pick_dma;
            inr_q   <= inr_d;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            be_q    <= sel_be;
         end
         // only the winner's read register moves; the other port holds
         if (state_q == ACCESS) begin
            if (win_q) begin
               d_rdata_q <= rd_val;
            end else begin
               c_rdata_q <= rd_val;
            end
         end
         if (state_q == RESP) begin
            last_q <= win_q;
         end
      end
   end

   always_comb begin
      busy       = (state_q != IDLE);
      mem_byteen = 4'h0;
      c_ack      = 1'b0;
      d_ack      = 1'b0;
      c_err      = 1'b0;
      d_err      = 1'b0;
      // reset in ACCESS kills the write in that same cycle
      if (state_q == ACCESS && inr_q && !reset) begin
         mem_byteen = be_q;
      end
      if (state_q == RESP) begin
         c_ack = ~win_q;
         d_ack = win_q;
         c_err = ~win_q & ~inr_q;
         d_err = win_q & ~inr_q;
      end
   end

   assign mem_addr  = addr_q & 32'hFFFF_FFFC;
   assign mem_wdata = wdata_q;
   assign c_rdata   = c_rdata_q;
   assign d_rdata   = d_rdata_q;

endmodule
